video_timing_gen: RTL



---
 rtl/video_timing_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel-rate raster timing (DE, syncs, {C1,C0}, coordinates, strobes) ahead of the TMDS encoders.
// Latency: every output is the registered decode of the counter position one clock earlier.
// Backpressure: none; enable=0 freezes the raster and gates DE/strobes. Colour bars: VIDEO_TIMING_GEN_PATTERN_EN.
module video_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [1:0]  ctrl,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        line_start,
   output logic        frame_start
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
   ,
   output logic [23:0] rgb
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_chk
         $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counters");
      end
   endgenerate

   // 13-bit bounds so a sync region ending exactly at 4096 still compares correctly.
   localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
   localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
   localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

   logic [11:0] h_q, h_d, v_q, v_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic        ls_q, ls_d, fs_q, fs_d;
   logic [12:0] h_ext, v_ext;

   assign h_ext = {1'b0, h_q};
   assign v_ext = {1'b0, v_q};

   always_comb begin
      h_d     = h_q;
      v_d     = v_q;
      x_d     = x_q;
      y_d     = y_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      de_d    = 1'b0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (enable) begin
         de_d    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
         hsync_d = (h_ext >= HS_START && h_ext < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d = (v_ext >= VS_START && v_ext < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
         x_d     = h_q;
         y_d     = v_q;
         ls_d    = (h_q == '0);
         fs_d    = (h_q == '0) && (v_q == '0);
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         de_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         hsync_q <= ~H_SYNC_POL;
         vsync_q <= ~V_SYNC_POL;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         x_q     <= x_d;
         y_q     <= y_d;
         de_q    <= de_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign ctrl        = {vsync_q, hsync_q};
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   generate
      if (BAR_W < 1) begin : g_bar_chk
         $error("video_timing_gen: H_ACTIVE too small for 8 colour bars");
      end
   endgenerate

   logic [23:0] rgb_q, rgb_d;
   logic [11:0] bar;

   // Bar colour follows de_d so the pattern lands on the same edge as DE.
   always_comb begin
      rgb_d = '0;
      bar   = h_q / 12'(BAR_W);
      if (de_d) begin
         case (bar)
            12'd0:   rgb_d = 24'hFFFFFF;
            12'd1:   rgb_d = 24'hFFFF00;
            12'd2:   rgb_d = 24'h00FFFF;
            12'd3:   rgb_d = 24'h00FF00;
            12'd4:   rgb_d = 24'hFF00FF;
            12'd5:   rgb_d = 24'hFF0000;
            12'd6:   rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= '0;
      else        rgb_q <= rgb_d;
   end

   assign rgb = rgb_q;
`endif

endmodule
